queue_doorbell_scheduler: RTL

// Round-robin dequeue scheduler feeding queue_manager. Latches doorbells into a per-queue active bitmap,

---
 rtl/queue_doorbell_scheduler.sv | 154 +++++++++++++++
 1 files changed

// File: rtl/queue_doorbell_scheduler.sv
// queue_doorbell_scheduler: round-robin doorbell-driven dequeue scheduler with in-flight op limit.
// Optional SCHED_STATS_EN adds saturating dequeue/empty statistics counters.
module queue_doorbell_scheduler #(
  parameter int QUEUE_INDEX_WIDTH = 8,
  parameter int REQ_TAG_WIDTH = 8,
  parameter int OP_TAG_WIDTH = 8,
  parameter int ADDR_WIDTH = 64,
  parameter int CPL_INDEX_WIDTH = 8,
  parameter int MAX_OUTSTANDING = 4,
  localparam int CW = $clog2(MAX_OUTSTANDING + 1)
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         enable,
  input  logic [QUEUE_INDEX_WIDTH-1:0] s_axis_doorbell_queue,
  input  logic                         s_axis_doorbell_valid,
  output logic [QUEUE_INDEX_WIDTH-1:0] m_axis_dequeue_req_queue,
  output logic [REQ_TAG_WIDTH-1:0]     m_axis_dequeue_req_tag,
  output logic                         m_axis_dequeue_req_valid,
  input  logic                         m_axis_dequeue_req_ready,
  input  logic [QUEUE_INDEX_WIDTH-1:0] s_axis_dequeue_resp_queue,
  input  logic [ADDR_WIDTH-1:0]        s_axis_dequeue_resp_addr,
  input  logic [CPL_INDEX_WIDTH-1:0]   s_axis_dequeue_resp_cpl,
  input  logic [REQ_TAG_WIDTH-1:0]     s_axis_dequeue_resp_tag,
  input  logic [OP_TAG_WIDTH-1:0]      s_axis_dequeue_resp_op_tag,
  input  logic                         s_axis_dequeue_resp_empty,
  input  logic                         s_axis_dequeue_resp_error,
  input  logic                         s_axis_dequeue_resp_valid,
  output logic                         s_axis_dequeue_resp_ready,
  output logic [QUEUE_INDEX_WIDTH-1:0] m_axis_fetch_req_queue,
  output logic [ADDR_WIDTH-1:0]        m_axis_fetch_req_addr,
  output logic [CPL_INDEX_WIDTH-1:0]   m_axis_fetch_req_cpl,
  output logic [OP_TAG_WIDTH-1:0]      m_axis_fetch_req_op_tag,
  output logic                         m_axis_fetch_req_valid,
  input  logic                         m_axis_fetch_req_ready,
  input  logic [OP_TAG_WIDTH-1:0]      s_axis_fetch_done_op_tag,
  input  logic                         s_axis_fetch_done_valid,
  output logic [OP_TAG_WIDTH-1:0]      m_axis_dequeue_commit_op_tag,
  output logic                         m_axis_dequeue_commit_valid,
  input  logic                         m_axis_dequeue_commit_ready,
  output logic [CW-1:0]                outstanding_count
`ifdef SCHED_STATS_EN
  ,
  output logic [31:0]                  stat_dequeue_count,
  output logic [31:0]                  stat_empty_count
`endif
);
  localparam int N = 1 << QUEUE_INDEX_WIDTH;
  typedef enum logic [1:0] {IDLE, REQ, WAIT_RESP, FETCH} state_t;
  state_t state;
  logic [N-1:0] bitmap;
  logic [QUEUE_INDEX_WIDTH-1:0] rr_ptr, sel, idx;
  logic found;
  logic [REQ_TAG_WIDTH-1:0] tag;
  logic req_hs, resp_hs, resp_drop, commit_hs;
  assign req_hs = m_axis_dequeue_req_valid & m_axis_dequeue_req_ready;
  assign resp_hs = s_axis_dequeue_resp_valid & s_axis_dequeue_resp_ready;
  // a response whose tag does not match the outstanding request is handled like an error
  assign resp_drop = resp_hs & (s_axis_dequeue_resp_empty | s_axis_dequeue_resp_error |
                                (s_axis_dequeue_resp_tag != m_axis_dequeue_req_tag));
  assign commit_hs = m_axis_dequeue_commit_valid & m_axis_dequeue_commit_ready;
  always_comb begin
    sel = '0;
    found = 1'b0;
    idx = '0;
    for (int i = 0; i < N; i++) begin
      idx = rr_ptr + QUEUE_INDEX_WIDTH'(i);
      if (!found && bitmap[idx]) begin
        sel = idx;
        found = 1'b1;
      end
    end
  end
  // set is written last so a same-cycle doorbell beats the clear
  always_ff @(posedge clk or posedge rst) begin
    if (rst) bitmap <= '0;
    else begin
      if (resp_drop) bitmap[s_axis_dequeue_resp_queue] <= 1'b0;
      if (s_axis_doorbell_valid) bitmap[s_axis_doorbell_queue] <= 1'b1;
    end
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) outstanding_count <= '0;
    else outstanding_count <= outstanding_count + CW'(req_hs) - CW'(resp_drop) - CW'(commit_hs);
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      rr_ptr <= '0;
      tag <= '0;
      m_axis_dequeue_req_queue <= '0;
      m_axis_dequeue_req_tag <= '0;
      m_axis_dequeue_req_valid <= 1'b0;
      s_axis_dequeue_resp_ready <= 1'b0;
      m_axis_fetch_req_queue <= '0;
      m_axis_fetch_req_addr <= '0;
      m_axis_fetch_req_cpl <= '0;
      m_axis_fetch_req_op_tag <= '0;
      m_axis_fetch_req_valid <= 1'b0;
    end else begin
      case (state)
        IDLE: if (enable && found && outstanding_count < CW'(MAX_OUTSTANDING)) begin
          state <= REQ;
          m_axis_dequeue_req_valid <= 1'b1;
          m_axis_dequeue_req_queue <= sel;
          m_axis_dequeue_req_tag <= tag;
        end
        REQ: if (m_axis_dequeue_req_ready) begin
          state <= WAIT_RESP;
          m_axis_dequeue_req_valid <= 1'b0;
          s_axis_dequeue_resp_ready <= 1'b1;
          tag <= tag + 1'b1;
          rr_ptr <= m_axis_dequeue_req_queue + 1'b1;
        end
        WAIT_RESP: if (s_axis_dequeue_resp_valid) begin
          s_axis_dequeue_resp_ready <= 1'b0;
          state <= resp_drop ? IDLE : FETCH;
          m_axis_fetch_req_valid <= !resp_drop;
          m_axis_fetch_req_queue <= s_axis_dequeue_resp_queue;
          m_axis_fetch_req_addr <= s_axis_dequeue_resp_addr;
          m_axis_fetch_req_cpl <= s_axis_dequeue_resp_cpl;
          m_axis_fetch_req_op_tag <= s_axis_dequeue_resp_op_tag;
        end
        FETCH: if (m_axis_fetch_req_ready) begin
          state <= IDLE;
          m_axis_fetch_req_valid <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      m_axis_dequeue_commit_valid <= 1'b0;
      m_axis_dequeue_commit_op_tag <= '0;
    end else if (s_axis_fetch_done_valid) begin
      m_axis_dequeue_commit_valid <= 1'b1;
      m_axis_dequeue_commit_op_tag <= s_axis_fetch_done_op_tag;
    end else if (m_axis_dequeue_commit_ready) m_axis_dequeue_commit_valid <= 1'b0;
  end
  always @(posedge clk)
    if (!rst) assert (!(s_axis_fetch_done_valid && m_axis_dequeue_commit_valid && !m_axis_dequeue_commit_ready));
`ifdef SCHED_STATS_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stat_dequeue_count <= '0;
      stat_empty_count <= '0;
    end else begin
      if (req_hs && !(&stat_dequeue_count)) stat_dequeue_count <= stat_dequeue_count + 1'b1;
      if (resp_drop && !(&stat_empty_count)) stat_empty_count <= stat_empty_count + 1'b1;
    end
  end
`endif
endmodule
